// File: rtl/instruction_fetch_if.sv
// Bundles the instruction-memory read bus and the fetch-to-decoder
// instruction channel of instruction_fetch.
//
// Handshakes: the decoder channel is strict valid/ready. Once instr_valid
// rises, instr and instr_pc stay stable and instr_valid stays high until
// the cycle in which instr_ready is also high. The transfer happens on that
// clock edge. The memory channel holds mem_rd_req and mem_addr stable until
// the cycle in which mem_ack is high, and mem_rdata is valid only in that
// cycle.
interface instruction_fetch_if #(
  parameter int IW = 16,
  parameter int AW = 16
);
  logic          mem_rd_req;
  logic [AW-1:0] mem_addr;
  logic          mem_ack;
  logic [IW-1:0] mem_rdata;
  logic          instr_valid;
  logic          instr_ready;
  logic [IW-1:0] instr;
  logic [AW-1:0] instr_pc;

  // Fetch unit side
  modport master (
    output mem_rd_req, mem_addr, instr_valid, instr, instr_pc,
    input  mem_ack, mem_rdata, instr_ready
  );

  // Memory/decoder side
  modport slave (
    input  mem_rd_req, mem_addr, instr_valid, instr, instr_pc,
    output mem_ack, mem_rdata, instr_ready
  );
endinterface

// File: rtl/instruction_fetch.sv
// Instruction fetch stage. It takes the PC from program_counter, performs one
// memory read per instruction word, and presents the word to the decoder.
// It pulses next_instruction_request once for each consumed word.
// The block never does address arithmetic. Branch handling and wrap-around
// belong to program_counter.
module instruction_fetch #(
  parameter int IW      = 16,
  parameter int AW      = 16,
  parameter int TIMEOUT = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [AW-1:0]       pc_i,
  output logic                next_instruction_request,
  input  logic                halt,
  output logic                busy,
  output logic                fetch_err,
  output logic [1:0]          state_o,
  instruction_fetch_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_HOLD  = 2'd2,
    S_ERROR = 2'd3
  } state_t;

  // The wait counter must be able to hold TIMEOUT itself. When the timeout is
  // disabled, the counter is a single saturating bit.
  localparam int              CW     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0]   TO_LIM = CW'(TIMEOUT);

  state_t        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] instr_q, instr_d;
  logic [AW-1:0] ipc_q, ipc_d;

  // State register. Reset always returns to IDLE, even from ERROR.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Datapath registers: latched PC, wait counter, captured word and its address.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q  <= '0;
      cnt_q   <= '0;
      instr_q <= '0;
      ipc_q   <= '0;
    end else begin
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
    end
  end

  // Next-state and datapath update rules.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    instr_d = instr_q;
    ipc_d   = ipc_q;
    case (state_q)
      S_IDLE: begin
        // This IDLE cycle follows every handshake. pc_i has therefore
        // already advanced by the time it is latched here.
        if (!halt) begin
          addr_d  = pc_i;
          cnt_d   = '0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        // An outstanding request always runs to completion, so halt is not
        // looked at here. An ack wins over a timeout in the same cycle.
        if (bus.mem_ack) begin
          instr_d = bus.mem_rdata;
          ipc_d   = addr_q;
          state_d = S_HOLD;
        end else begin
          if (cnt_q != {CW{1'b1}}) cnt_d = cnt_q + 1'b1;
          if ((TIMEOUT != 0) && (cnt_d == TO_LIM)) state_d = S_ERROR;
        end
      end
      S_HOLD: begin
        if (bus.instr_ready) state_d = S_IDLE;
      end
      default: begin
        // ERROR is sticky. Only rst leaves it, and mem_ack is ignored.
        state_d = S_ERROR;
      end
    endcase
  end

  // Moore outputs decoded from state, plus the combinational advance pulse.
  always_comb begin
    bus.mem_rd_req           = 1'b0;
    bus.mem_addr             = '0;
    bus.instr_valid          = 1'b0;
    next_instruction_request = 1'b0;
    busy                     = 1'b0;
    fetch_err                = 1'b0;
    case (state_q)
      S_ISSUE: begin
        bus.mem_rd_req = 1'b1;
        bus.mem_addr   = addr_q;
        busy           = 1'b1;
      end
      S_HOLD: begin
        bus.instr_valid          = 1'b1;
        next_instruction_request = bus.instr_ready;
        busy                     = 1'b1;
      end
      S_ERROR: fetch_err = 1'b1;
      default: ;
    endcase
  end

  assign bus.instr    = instr_q;
  assign bus.instr_pc = ipc_q;
  assign state_o      = state_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch. A simple program_counter model drives pc_i.
// A table of per-cycle vectors covers reset, streaming, wait states,
// backpressure and halt. Hand-written sequences cover branches, wrap-around,
// mid-operation reset and timeout. A randomized run checks the DUT against
// an expected-instruction queue and an expected-address rule.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        halt;
  logic [15:0] pc_q;
  logic        nir, busy, fetch_err;
  logic [1:0]  state_dbg;

  // Decoder-driven branch controls seen by the program_counter model
  logic        br_take, br_rel;
  logic [15:0] br_abs;
  logic [7:0]  br_off;

  int          n_chk  = 0;
  int          n_fail = 0;
  logic [15:0] exp_pc;
  logic [31:0] exp_q[$];

  instruction_fetch_if #(.IW(16), .AW(16)) bus ();

  instruction_fetch #(.IW(16), .AW(16), .TIMEOUT(64)) dut (
    .clk                     (clk),
    .rst                     (rst),
    .pc_i                    (pc_q),
    .next_instruction_request(nir),
    .halt                    (halt),
    .busy                    (busy),
    .fetch_err               (fetch_err),
    .state_o                 (state_dbg),
    .bus                     (bus)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // Behavioural program_counter: reset address 0x1000; advance or branch on the pulse
  always @(posedge clk) begin
    if (rst)      pc_q <= 16'h1000;
    else if (nir) pc_q <= br_take ? (br_rel ? pc_q + {{8{br_off[7]}}, br_off} : br_abs)
                                  : pc_q + 16'd1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic next_cyc();
    @(negedge clk);
  endtask

  task automatic do_reset();
    next_cyc();
    rst = 1'b1; halt = 1'b0; bus.mem_ack = 1'b0; bus.instr_ready = 1'b0; br_take = 1'b0;
    next_cyc();
    next_cyc();
    rst = 1'b0;
    exp_q.delete();
    exp_pc = 16'h1000;
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_req"},   32'(bus.mem_rd_req),  0);
    check({tag, "_addr"},  32'(bus.mem_addr),    0);
    check({tag, "_valid"}, 32'(bus.instr_valid), 0);
    check({tag, "_instr"}, 32'(bus.instr),       0);
    check({tag, "_ipc"},   32'(bus.instr_pc),    0);
    check({tag, "_nir"},   32'(nir),             0);
    check({tag, "_busy"},  32'(busy),            0);
    check({tag, "_err"},   32'(fetch_err),       0);
  endtask

  // One full fetch: optional halt in IDLE, `waits` no-ack cycles, then
  // `rdy_dly` backpressure cycles before the decoder accepts.
  task automatic fetch_one(input logic [15:0] ea, input logic [15:0] data, input int waits,
                           input int rdy_dly, input int hold_off, input logic take,
                           input logic rel, input logic [15:0] tgt);
    int n;
    logic [31:0] e;
    next_cyc();
    bus.mem_ack = 1'b0; bus.instr_ready = 1'b0; br_take = 1'b0; halt = (hold_off > 0);
    #1;
    n = 0;
    while (!bus.mem_rd_req && n < 16) begin
      next_cyc();
      n++;
      halt = (n < hold_off);
      #1;
    end
    check("req_start", 32'(bus.mem_rd_req), 1);
    for (int w = 0; w <= waits; w++) begin
      if (w > 0) begin
        next_cyc();
        #1;
        check("req_held", 32'(bus.mem_rd_req), 1);
      end
      check("req_addr", 32'(bus.mem_addr), 32'(ea));
      check("req_busy", 32'(busy), 1);
      bus.mem_ack   = (w == waits);
      bus.mem_rdata = (w == waits) ? data : 16'($urandom);
      halt          = 1'($urandom_range(0, 1));
    end
    exp_q.push_back({data, ea});
    for (int d = 0; d <= rdy_dly; d++) begin
      next_cyc();
      bus.mem_ack     = 1'($urandom_range(0, 1));
      bus.mem_rdata   = 16'($urandom);
      halt            = 1'b0;
      bus.instr_ready = (d == rdy_dly);
      if (d == rdy_dly) begin
        br_take = take; br_rel = rel; br_abs = tgt; br_off = tgt[7:0];
      end
      #1;
      e = exp_q[0];
      check("hold_valid", 32'(bus.instr_valid), 1);
      check("hold_instr", 32'(bus.instr), 32'(e[31:16]));
      check("hold_ipc",   32'(bus.instr_pc), 32'(e[15:0]));
      check("hold_nir",   32'(nir), (d == rdy_dly) ? 1 : 0);
      check("hold_req",   32'(bus.mem_rd_req), 0);
    end
    void'(exp_q.pop_front());
    exp_pc = take ? (rel ? ea + {{8{tgt[7]}}, tgt[7:0]} : tgt) : ea + 16'd1;
    next_cyc();
    bus.instr_ready = 1'b0; br_take = 1'b0;
    bus.mem_ack = 1'($urandom_range(0, 1)); bus.mem_rdata = 16'($urandom);
    halt = 1'($urandom_range(0, 1));
    #1;
    check("idle_valid", 32'(bus.instr_valid), 0);
    check("idle_nir",   32'(nir), 0);
    check("idle_busy",  32'(busy), 0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic rst, halt, ack; logic [15:0] rdata; logic rdy;
    logic req; logic [15:0] addr; logic v; logic [15:0] ins, ipc; logic nir, busy, err;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(input logic r, input logic h, input logic a, input logic [15:0] rd,
                              input logic rdy, input logic req, input logic [15:0] ad,
                              input logic v, input logic [15:0] ins, input logic [15:0] ipc,
                              input logic n, input logic b, input logic er);
    vec_t t;
    t.rst = r; t.halt = h; t.ack = a; t.rdata = rd; t.rdy = rdy;
    t.req = req; t.addr = ad; t.v = v; t.ins = ins; t.ipc = ipc; t.nir = n; t.busy = b; t.err = er;
    return t;
  endfunction

  initial begin
    int n;
    rst = 1'b1; halt = 1'b0; br_take = 1'b0; br_rel = 1'b0; br_abs = '0; br_off = '0;
    bus.mem_ack = 1'b0; bus.mem_rdata = '0; bus.instr_ready = 1'b0;
    exp_pc = 16'h1000;

    // reset, first fetch with zero-wait ack
    tv.push_back(mk(1,0,0,16'h0000,0, 0,16'h0000,0,16'h0000,16'h0000,0,0,0));
    tv.push_back(mk(1,0,0,16'h0000,0, 0,16'h0000,0,16'h0000,16'h0000,0,0,0));
    tv.push_back(mk(0,0,0,16'h0000,0, 0,16'h0000,0,16'h0000,16'h0000,0,0,0));
    tv.push_back(mk(0,0,1,16'hA5A5,0, 1,16'h1000,0,16'h0000,16'h0000,0,1,0));
    tv.push_back(mk(0,0,0,16'h0000,1, 0,16'h0000,1,16'hA5A5,16'h1000,1,1,0));
    // reset again from IDLE, then a 3-word zero-wait stream
    tv.push_back(mk(1,0,0,16'h0000,0, 0,16'h0000,0,16'hA5A5,16'h1000,0,0,0));
    tv.push_back(mk(0,0,0,16'h0000,0, 0,16'h0000,0,16'h0000,16'h0000,0,0,0));
    tv.push_back(mk(0,0,1,16'h0001,0, 1,16'h1000,0,16'h0000,16'h0000,0,1,0));
    tv.push_back(mk(0,0,0,16'h0000,1, 0,16'h0000,1,16'h0001,16'h1000,1,1,0));
    tv.push_back(mk(0,0,0,16'h0000,0, 0,16'h0000,0,16'h0001,16'h1000,0,0,0));
    tv.push_back(mk(0,0,1,16'h0002,0, 1,16'h1001,0,16'h0001,16'h1000,0,1,0));
    tv.push_back(mk(0,0,0,16'h0000,1, 0,16'h0000,1,16'h0002,16'h1001,1,1,0));
    tv.push_back(mk(0,0,0,16'h0000,0, 0,16'h0000,0,16'h0002,16'h1001,0,0,0));
    tv.push_back(mk(0,0,1,16'h0003,0, 1,16'h1002,0,16'h0002,16'h1001,0,1,0));
    tv.push_back(mk(0,0,0,16'h0000,1, 0,16'h0000,1,16'h0003,16'h1002,1,1,0));
    tv.push_back(mk(0,0,0,16'h0000,0, 0,16'h0000,0,16'h0003,16'h1002,0,0,0));
    // five wait states (garbage rdata without ack), ack on the sixth request cycle
    for (int i = 0; i < 5; i++)
      tv.push_back(mk(0,0,0,16'hDEAD,0, 1,16'h1003,0,16'h0003,16'h1002,0,1,0));
    tv.push_back(mk(0,0,1,16'hBEEF,0, 1,16'h1003,0,16'h0003,16'h1002,0,1,0));
    // four cycles of backpressure, then a single advance pulse
    for (int i = 0; i < 4; i++)
      tv.push_back(mk(0,0,0,16'h0000,0, 0,16'h0000,1,16'hBEEF,16'h1003,0,1,0));
    tv.push_back(mk(0,0,0,16'h0000,1, 0,16'h0000,1,16'hBEEF,16'h1003,1,1,0));
    // halt in IDLE blocks fetch; stray acks in IDLE are ignored
    tv.push_back(mk(0,1,0,16'h0000,0, 0,16'h0000,0,16'hBEEF,16'h1003,0,0,0));
    tv.push_back(mk(0,1,1,16'hFFFF,0, 0,16'h0000,0,16'hBEEF,16'h1003,0,0,0));
    tv.push_back(mk(0,0,1,16'hFFFF,0, 0,16'h0000,0,16'hBEEF,16'h1003,0,0,0));
    // halt raised during ISSUE: the request still completes
    tv.push_back(mk(0,1,0,16'h0000,0, 1,16'h1004,0,16'hBEEF,16'h1003,0,1,0));
    tv.push_back(mk(0,1,1,16'h1234,0, 1,16'h1004,0,16'hBEEF,16'h1003,0,1,0));
    tv.push_back(mk(0,1,0,16'h0000,1, 0,16'h0000,1,16'h1234,16'h1004,1,1,0));
    tv.push_back(mk(0,1,0,16'h0000,0, 0,16'h0000,0,16'h1234,16'h1004,0,0,0));

    @(posedge clk);
    foreach (tv[i]) begin
      next_cyc();
      rst = tv[i].rst; halt = tv[i].halt; bus.mem_ack = tv[i].ack;
      bus.mem_rdata = tv[i].rdata; bus.instr_ready = tv[i].rdy;
      #1;
      check($sformatf("row%0d_req", i),   32'(bus.mem_rd_req),  32'(tv[i].req));
      check($sformatf("row%0d_addr", i),  32'(bus.mem_addr),    32'(tv[i].addr));
      check($sformatf("row%0d_valid", i), 32'(bus.instr_valid), 32'(tv[i].v));
      check($sformatf("row%0d_instr", i), 32'(bus.instr),       32'(tv[i].ins));
      check($sformatf("row%0d_ipc", i),   32'(bus.instr_pc),    32'(tv[i].ipc));
      check($sformatf("row%0d_nir", i),   32'(nir),             32'(tv[i].nir));
      check($sformatf("row%0d_busy", i),  32'(busy),            32'(tv[i].busy));
      check($sformatf("row%0d_err", i),   32'(fetch_err),       32'(tv[i].err));
    end

    // ---- branches and wrap-around (PC is 0x1005 after the table) ----
    fetch_one(16'h1005, 16'h1111, 0, 0, 2, 1'b1, 1'b0, 16'h7843);
    fetch_one(16'h7843, 16'h2222, 1, 1, 0, 1'b0, 1'b0, 16'h0000);
    fetch_one(16'h7844, 16'h3333, 0, 0, 0, 1'b0, 1'b0, 16'h0000);
    fetch_one(16'h7845, 16'h4444, 2, 0, 1, 1'b0, 1'b0, 16'h0000);
    fetch_one(16'h7846, 16'h5555, 0, 2, 0, 1'b1, 1'b1, 16'h0084);
    fetch_one(16'h77CA, 16'h6666, 0, 0, 0, 1'b1, 1'b0, 16'hFFFF);
    fetch_one(16'hFFFF, 16'h7777, 0, 0, 0, 1'b0, 1'b0, 16'h0000);
    fetch_one(16'h0000, 16'h8888, 0, 0, 0, 1'b0, 1'b0, 16'h0000);

    // ---- reset while in HOLD ----
    do_reset();
    next_cyc(); bus.mem_ack = 1'b1; bus.mem_rdata = 16'h5A5A; #1;
    check("post_rst_req",  32'(bus.mem_rd_req), 1);
    check("post_rst_addr", 32'(bus.mem_addr), 32'h1000);
    next_cyc(); rst = 1'b1; bus.mem_ack = 1'b1; bus.mem_rdata = 16'hDEAD; #1;
    check("pre_hold_rst_instr", 32'(bus.instr), 32'h5A5A);
    next_cyc(); #1;
    check_reset_outs("rst_in_hold");
    next_cyc(); rst = 1'b0; bus.mem_ack = 1'b0; #1;
    check_reset_outs("rst_hold_rel");
    // ---- reset while in ISSUE, with an ack arriving during reset ----
    next_cyc(); #1;
    check("issue2_req", 32'(bus.mem_rd_req), 1);
    rst = 1'b1; bus.mem_ack = 1'b1; bus.mem_rdata = 16'hDEAD;
    next_cyc(); #1;
    check_reset_outs("rst_in_issue");
    next_cyc(); rst = 1'b0; bus.mem_ack = 1'b0; #1;
    check_reset_outs("rst_issue_rel");
    exp_pc = 16'h1000;

    // ---- ack on the last cycle before the timeout still wins ----
    fetch_one(16'h1000, 16'hC0DE, 63, 0, 0, 1'b0, 1'b0, 16'h0000);
    check("no_err_at_63", 32'(fetch_err), 0);

    // ---- timeout: 64 request cycles without ack ----
    do_reset();
    next_cyc(); bus.mem_ack = 1'b0; #1;
    n = 0;
    while (bus.mem_rd_req && n < 200) begin
      n++;
      next_cyc(); #1;
    end
    check("timeout_req_cycles", 32'(n), 64);
    check("timeout_err", 32'(fetch_err), 1);
    check("timeout_busy", 32'(busy), 0);
    for (int i = 0; i < 5; i++) begin
      next_cyc(); bus.mem_ack = 1'b1; bus.mem_rdata = 16'hBAD0; bus.instr_ready = 1'b1; #1;
      check("err_sticky", 32'(fetch_err), 1);
      check("err_no_req", 32'(bus.mem_rd_req), 0);
      check("err_no_valid", 32'(bus.instr_valid), 0);
    end
    do_reset();
    #1;
    check("err_cleared", 32'(fetch_err), 0);

    // ---- randomized stream against the scoreboard ----
    for (int i = 0; i < 150; i++) begin
      logic take;
      take = ($urandom_range(0, 7) == 0);
      fetch_one(exp_pc, 16'($urandom), $urandom_range(0, 6), $urandom_range(0, 4),
                $urandom_range(0, 2), take, 1'($urandom_range(0, 1)), 16'($urandom));
    end
    check("scoreboard_empty", 32'(exp_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
- Sits directly downstream of program_counter and upstream of the instruction decoder.
- Samples pc_o (on pc_i) and issues one read per instruction word on the instruction-memory bus, tolerating wait states.
- Holds the returned word for the decoder under a valid/ready handshake.
- Pulses next_instruction_request so the program counter advances, or branches using the decoder-driven condition/jump inputs, exactly once per consumed instruction.

Parameters:
- IW, 16, instruction word width in bits (one word per PC address).
- AW, 16, address width; must match the program_counter output.
- TIMEOUT, 64, maximum consecutive request cycles without mem_ack before a fetch error; 0 disables the timeout.

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  reset, synchronous, active-high.
- pc_i  in  AW  current PC from program_counter.pc_o.
- next_instruction_request  out  1  to program_counter; high for exactly one cycle per consumed instruction.
- mem_rd_req  out  1  instruction-memory read request.
- mem_addr  out  AW  read address; stable while mem_rd_req is high.
- mem_ack  in  1  memory has returned data on mem_rdata this cycle.
- mem_rdata  in  IW  read data; valid only with mem_ack.
- instr_valid  out  1  instr/instr_pc hold a fetched instruction.
- instr_ready  in  1  decoder accepts the instruction.
- instr  out  IW  fetched instruction word.
- instr_pc  out  AW  address the instruction was fetched from.
- halt  in  1  suppresses starting new fetches.
- busy  out  1  high in ISSUE or HOLD.
- fetch_err  out  1  sticky bus-timeout flag.

Behaviour:
- One clock domain. All state updates on rising clk; rst is synchronous and active-high, sampled on rising clk.
- Reset values (any state, including mid-fetch or mid-hold):
  - state=IDLE;
  - mem_rd_req=0, mem_addr=0;
  - instr_valid=0, instr=0, instr_pc=0;
  - next_instruction_request=0, busy=0, fetch_err=0;
  - wait counter=0.
- FSM states: IDLE, ISSUE, HOLD, ERROR.
- IDLE:
  - If halt=0: latch addr_q<=pc_i, clear the wait counter, go to ISSUE.
  - If halt=1: stay in IDLE.
  - Exactly one IDLE cycle always follows a handshake, so pc_i has already advanced when it is latched.
- ISSUE:
  - mem_rd_req=1, mem_addr=addr_q, both stable until ack.
  - On mem_ack=1: instr<=mem_rdata, instr_pc<=addr_q, go to HOLD. A zero-wait ack in the first ISSUE cycle is legal.
  - Else: wait counter += 1. If TIMEOUT!=0 and the counter reaches TIMEOUT, go to ERROR.
  - halt has no effect in ISSUE; an outstanding request always completes.
- HOLD:
  - instr_valid=1; instr and instr_pc are held stable.
  - next_instruction_request = instr_valid & instr_ready (combinational).
  - On handshake go to IDLE. program_counter updates on that same edge.
  - No handshake: stay in HOLD indefinitely.
- ERROR:
  - fetch_err=1, all other outputs inactive, mem_ack ignored.
  - Only rst leaves ERROR.
- mem_ack outside ISSUE is ignored, and no data is captured.
- Throughput: back-to-back consumption with zero-wait memory yields one instruction per 3 cycles (IDLE, ISSUE, HOLD).
- Latency after rst release: mem_rd_req rises 1 cycle later with mem_addr=0x1000 (the program_counter reset address).
- Address arithmetic belongs solely to program_counter; this block never modifies the address. Wrap-around (0xFFFF to 0x0000) is therefore transparent.
- The wait counter saturates and never wraps.

Test Plan:
- Reset/first fetch:
  - Assert rst 2 cycles, release, zero-wait ack with mem_rdata=0xA5A5 → mem_rd_req high 1 cycle after release at mem_addr=0x1000.
  - Next cycle: instr_valid=1, instr=0xA5A5, instr_pc=0x1000.
- Sequential stream:
  - instr_ready held 1, memory returns 0x0001, 0x0002, 0x0003 with zero wait → next_instruction_request pulses once per instruction, 3 cycles apart.
  - Addresses issued are 0x1000, 0x1001, 0x1002.
- Wait states and backpressure:
  - mem_ack delayed 5 cycles → mem_addr stable throughout.
  - With instr_ready=0 for 4 cycles: instr held, no next_instruction_request.
  - Asserting instr_ready gives a single-cycle pulse.
- Branch:
  - Decoder drives condition_is_true=1, call_or_jump=1, absolute=0x7843 during the handshake → next mem_addr=0x7843.
  - Relative offset 0x84 from 0x7846 → next mem_addr=0x77CA.
- Halt/timeout:
  - halt=1 in IDLE → no mem_rd_req.
  - halt=1 during ISSUE → the request still completes.
  - With TIMEOUT=64 and no ack → fetch_err=1 after 64 request cycles, and it stays set until rst.
- Reset mid-operation:
  - Assert rst while in ISSUE, and separately while in HOLD → on the next edge all outputs are at reset values.
  - A mem_ack arriving during reset is ignored.
